// File: rtl/sram_byte_ctrl_if.sv
// Processor-side request/response bundle for sram_byte_ctrl.
// ByteMode exists only when SRAM_CTRL_BYTE_ACCESS_EN is defined.
interface sram_byte_ctrl_if;
  logic        Req;
  logic        Write;
  logic [20:0] Addr;
  logic [15:0] WrData;
  logic [15:0] RdData;
  logic        Ack;
  logic        Busy;
`ifdef SRAM_CTRL_BYTE_ACCESS_EN
  logic        ByteMode;

  modport master (output Req, Write, Addr, WrData, ByteMode,
                  input  RdData, Ack, Busy);
  modport slave  (input  Req, Write, Addr, WrData, ByteMode,
                  output RdData, Ack, Busy);
`else
  modport master (output Req, Write, Addr, WrData,
                  input  RdData, Ack, Busy);
  modport slave  (input  Req, Write, Addr, WrData,
                  output RdData, Ack, Busy);
`endif
endinterface

// File: rtl/sram_byte_ctrl.sv
// Sequences 16-bit word requests into two big-endian byte accesses on an async 8-bit SRAM.
// Define SRAM_CTRL_BYTE_ACCESS_EN to add single-byte accesses via bus.ByteMode.
module sram_byte_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              nReset,
  sram_byte_ctrl_if.slave   bus,
  output logic              cs,
  output logic              we,
  output logic              oe,
  output logic [20:0]       SramAddr,
  inout  wire  [7:0]        SramData
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("sram_byte_ctrl: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_e;

  state_e      state_q;
  logic        write_q;
  logic        hi_q;
  logic        byte_q;
  logic        drive_q;
  logic        cs_q;
  logic        we_q;
  logic        oe_q;
  logic        ack_q;
  logic        busy_q;
  logic [3:0]  wait_q;
  logic [20:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [7:0]  dout_q;

  logic        req_byte;
  logic        last_phase;
  logic        phase_done;
  logic [7:0]  wr_byte;

`ifdef SRAM_CTRL_BYTE_ACCESS_EN
  assign req_byte = bus.ByteMode;
`else
  assign req_byte = 1'b0;
`endif

  // A byte-mode access is a single phase, so it always behaves as the last one.
  assign last_phase = byte_q || !hi_q;
  assign wr_byte    = (hi_q && !byte_q) ? wdata_q[15:8] : wdata_q[7:0];
  assign phase_done = (state_q == HOLD) ||
                      (state_q == STROBE && wait_q == 4'd0 && !write_q);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside this block.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      hi_q    <= 1'b1;
      byte_q  <= 1'b0;
      drive_q <= 1'b0;
      cs_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      wait_q  <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Req) begin
            write_q <= bus.Write;
            byte_q  <= req_byte;
            wdata_q <= bus.WrData;
            addr_q  <= req_byte ? bus.Addr : {bus.Addr[20:1], 1'b0};
            hi_q    <= 1'b1;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          wait_q <= WAIT_LOAD;
          if (write_q) begin
            we_q    <= 1'b0;
            drive_q <= 1'b1;
            dout_q  <= wr_byte;
          end else begin
            oe_q <= 1'b0;
          end
          state_q <= STROBE;
        end
        STROBE: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (write_q) begin
            we_q    <= 1'b1;
            state_q <= HOLD;
          end else begin
            oe_q <= 1'b1;
            if (byte_q)    rdata_q       <= {8'h00, SramData};
            else if (hi_q) rdata_q[15:8] <= SramData;
            else           rdata_q[7:0]  <= SramData;
          end
        end
        HOLD: begin
          drive_q <= 1'b0;
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Shared exit of a byte phase: either start the low byte or finish.
      if (phase_done) begin
        if (last_phase) begin
          cs_q    <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= ACK;
        end else begin
          hi_q    <= 1'b0;
          addr_q  <= {addr_q[20:1], 1'b1};
          state_q <= SETUP;
        end
      end
    end
  end

  assign cs         = cs_q;
  assign we         = we_q;
  assign oe         = oe_q;
  assign SramAddr   = addr_q;
  assign SramData   = drive_q ? dout_q : 8'bz;
  assign bus.RdData = rdata_q;
  assign bus.Ack    = ack_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Scoreboard bench for sram_byte_ctrl with a behavioural async SRAM on the byte bus.
// Byte-mode vectors run only when SRAM_CTRL_BYTE_ACCESS_EN is defined.
module tb_sram_byte_ctrl;

  // Hand-computed latencies (accept negedge -> Ack negedge) for WAIT_CYCLES=2.
  localparam int unsigned RD_LAT  = 7;  // 2*(2+1)+1
  localparam int unsigned WR_LAT  = 9;  // 2*(2+2)+1
  localparam int unsigned BRD_LAT = 4;  // (2+1)+1
  localparam int unsigned BWR_LAT = 5;  // (2+2)+1

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int unsigned cyc;
    string       name;
  } exp_t;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        cs, we, oe;
  logic [20:0] SramAddr;
  wire  [7:0]  SramData;

  logic [7:0]  mem [64];
  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  sram_byte_ctrl_if bus ();

  sram_byte_ctrl #(.WAIT_CYCLES(2)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .bus      (bus),
    .cs       (cs),
    .we       (we),
    .oe       (oe),
    .SramAddr (SramAddr),
    .SramData (SramData)
  );

  always #5 Clock = ~Clock;

  // Async SRAM model: drives on read enable, stores while the write strobe is low.
  assign SramData = (!cs && !oe) ? mem[SramAddr[5:0]] : 8'bz;
  always @(posedge Clock) begin
    if (!cs && !we) mem[SramAddr[5:0]] <= SramData;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: bus invariants every cycle, and scoreboard pop on each Ack.
  always @(negedge Clock) begin
    if (nReset) begin
      check("we_oe_exclusive", {31'b0, (!we && !oe)}, 32'd0);
      check("drive_while_oe", {31'b0, (dut.drive_q && !oe)}, 32'd0);
      if (!bus.Busy) check("cs_high_idle", {31'b0, cs}, 32'd1);
      if (bus.Ack) begin
        if (q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check({mon_e.name, "_ack_cycle"}, cyc, mon_e.cyc);
          check({mon_e.name, "_ack_cs"}, {31'b0, cs}, 32'd1);
          check({mon_e.name, "_ack_busy"}, {31'b0, bus.Busy}, 32'd1);
          if (mon_e.rd) check({mon_e.name, "_rddata"}, {16'b0, bus.RdData}, {16'b0, mon_e.data});
        end
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge Clock);
      if (!bus.Busy) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(negedge Clock);
      if (q.size() == 0 && !bus.Busy) return;
    end
    check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input string name, input bit wr, input logic [20:0] a,
                       input logic [15:0] wd, input bit bm, input logic [15:0] exp_rd);
    exp_t        e;
    int unsigned lat;
    wait_idle();
    bus.Req    = 1'b1;
    bus.Write  = wr;
    bus.Addr   = a;
    bus.WrData = wd;
`ifdef SRAM_CTRL_BYTE_ACCESS_EN
    bus.ByteMode = bm;
`endif
    @(posedge Clock);
    @(negedge Clock);
    bus.Req = 1'b0;
`ifdef SRAM_CTRL_BYTE_ACCESS_EN
    bus.ByteMode = 1'b0;
`endif
    lat    = bm ? (wr ? BWR_LAT : BRD_LAT) : (wr ? WR_LAT : RD_LAT);
    e.rd   = !wr;
    e.data = exp_rd;
    e.cyc  = cyc + lat - 1;
    e.name = name;
    q.push_back(e);
    check({name, "_busy_after_accept"}, {31'b0, bus.Busy}, 32'd1);
  endtask

  // Held-Req stimulus table.
  bit          tbl_w [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [20:0] tbl_a [7] = '{21'd8, 21'd9, 21'd10, 21'd8, 21'd11, 21'd8, 21'd10};
  logic [15:0] tbl_d [7] = '{16'hCAFE, 16'h0000, 16'h0BAD, 16'h0000, 16'h0000, 16'h1357, 16'h0000};

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] shadow [32];
    int unsigned next_present;
    int unsigned lat;
    int          idx;
    exp_t        e;

    for (int i = 0; i < 64; i++) mem[i] = 8'h55;
    for (int i = 0; i < 32; i++) shadow[i] = 16'h5555;
    bus.Req    = 1'b0;
    bus.Write  = 1'b0;
    bus.Addr   = '0;
    bus.WrData = '0;
`ifdef SRAM_CTRL_BYTE_ACCESS_EN
    bus.ByteMode = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge Clock);
    check("rst_cs", {31'b0, cs}, 32'd1);
    check("rst_we", {31'b0, we}, 32'd1);
    check("rst_oe", {31'b0, oe}, 32'd1);
    check("rst_drive", {31'b0, dut.drive_q}, 32'd0);
    check("rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("rst_ack", {31'b0, bus.Ack}, 32'd0);
    check("rst_rddata", {16'b0, bus.RdData}, 32'd0);
    check("rst_sramaddr", {11'b0, SramAddr}, 32'd0);
    nReset = 1'b1;

    // Word read from filled SRAM, then write/read-back with odd read address.
    issue("rd0", 1'b0, 21'h000000, 16'h0000, 1'b0, 16'h5555);
    issue("wr4", 1'b1, 21'h000004, 16'hBEEF, 1'b0, 16'h0000);
    drain();
    check("mem4", {24'b0, mem[4]}, 32'hBE);
    check("mem5", {24'b0, mem[5]}, 32'hEF);
    issue("rd5", 1'b0, 21'h000005, 16'h0000, 1'b0, 16'hBEEF);
    drain();

    // Req held high with changing inputs: only requests at IDLE edges count.
    wait_idle();
    next_present = cyc;
    for (int i = 0; i < 70; i++) begin
      idx = i % 7;
      bus.Req    = 1'b1;
      bus.Write  = tbl_w[idx];
      bus.Addr   = tbl_a[idx];
      bus.WrData = tbl_d[idx];
      if (cyc == next_present) begin
        lat    = tbl_w[idx] ? WR_LAT : RD_LAT;
        e.rd   = !tbl_w[idx];
        e.data = shadow[tbl_a[idx][5:1]];
        e.cyc  = cyc + lat;
        e.name = $sformatf("held%0d", i);
        q.push_back(e);
        if (tbl_w[idx]) shadow[tbl_a[idx][5:1]] = tbl_d[idx];
        next_present = cyc + lat + 1;
      end
      @(negedge Clock);
    end
    bus.Req = 1'b0;
    drain();

`ifdef SRAM_CTRL_BYTE_ACCESS_EN
    issue("bm_wr6", 1'b1, 21'd6, 16'h1234, 1'b0, 16'h0000);
    issue("bm_bwr7", 1'b1, 21'd7, 16'h00A5, 1'b1, 16'h0000);
    issue("bm_rd6", 1'b0, 21'd6, 16'h0000, 1'b0, 16'h12A5);
    issue("bm_brd6", 1'b0, 21'd6, 16'h0000, 1'b1, 16'h0012);
    issue("bm_brd7", 1'b0, 21'd7, 16'h0000, 1'b1, 16'h00A5);
    drain();
`endif

    // Reset during the second strobe cycle of a write: no Ack, bus released at once.
    wait_idle();
    bus.Req    = 1'b1;
    bus.Write  = 1'b1;
    bus.Addr   = 21'd20;
    bus.WrData = 16'h7788;
    @(posedge Clock);
    @(negedge Clock);
    bus.Req = 1'b0;
    repeat (2) @(negedge Clock);
    check("mid_we_low", {31'b0, we}, 32'd0);
    #2 nReset = 1'b0;
    #1;
    check("arst_we", {31'b0, we}, 32'd1);
    check("arst_oe", {31'b0, oe}, 32'd1);
    check("arst_cs", {31'b0, cs}, 32'd1);
    check("arst_drive", {31'b0, dut.drive_q}, 32'd0);
    check("arst_busy", {31'b0, bus.Busy}, 32'd0);
    check("arst_rddata", {16'b0, bus.RdData}, 32'd0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    issue("rd0_after_rst", 1'b0, 21'h000000, 16'h0000, 1'b0, 16'h5555);
    drain();
    repeat (5) @(negedge Clock);

    check("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_byte_ctrl.md
# sram_byte_ctrl

Synchronous controller between the processor's memory port and the external 8-bit asynchronous SRAM (active-low cs/we/oe, 21-bit address, bidirectional byte bus). It turns single-cycle 16-bit word read/write requests into two sequenced byte accesses, big-endian: even address = high byte. It owns SRAM bus direction, so oe and we are never low together and the data bus is driven only during writes.

## Interface
- WAIT_CYCLES, 2, strobe length per byte access in clock cycles (legal 1..15).
- Clock  in  1  system clock, all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Req  in  1  request; accepted on a rising edge when Busy=0.
- Write  in  1  1 = write, 0 = read; sampled with Req.
- Addr  in  21  byte address; bit 0 ignored for word access.
- WrData  in  16  write word; sampled with Req.
- RdData  out  16  read word; valid from the Ack cycle until the next accepted read.
- Ack  out  1  one-cycle completion pulse.
- Busy  out  1  high from the cycle after acceptance through the Ack cycle.
- cs  out  1  SRAM chip select, active low.
- we  out  1  SRAM write enable, active low.
- oe  out  1  SRAM output enable, active low.
- SramAddr  out  21  SRAM byte address.
- SramData  inout  8  SRAM data bus; driven only in the write strobe and hold states, otherwise 'z.

## Operation
- All outputs are registered. Reset values: cs=we=oe=1, SramAddr=0, SramData='z, RdData=0, Ack=0, Busy=0, state IDLE, byte select=high.
- Accept: in IDLE, when Req=1, latch Write, {Addr[20:1],0} and WrData, then go to SETUP with byte select=high.
- FSM states: IDLE, SETUP, STROBE, HOLD, ACK.
  - IDLE -> SETUP on accept.
  - SETUP: 1 cycle; cs=0, we=oe=1; SramAddr = base, plus 1 for the low byte. -> STROBE, wait counter loaded.
  - STROBE: WAIT_CYCLES cycles.
    - Read: oe=0. On the final strobe edge, SramData is captured into RdData[15:8] (high byte) or RdData[7:0] (low byte).
    - Write: we=0 and SramData = selected byte of the write word.
    - Exit: read -> (high ? SETUP(low) : ACK); write -> HOLD.
  - HOLD (write only): 1 cycle; we=1, data still driven, cs=0. -> (high ? SETUP(low) : ACK).
  - ACK: 1 cycle; cs=1, Ack=1, Busy=1, bus 'z. -> IDLE.
- Invariants:
  - we and oe are never both 0.
  - SramData is never driven while oe=0.
  - cs=1 in IDLE and ACK.
- Req while Busy=1 is ignored, not queued. Req held high gives back-to-back transactions with one IDLE cycle between them.
- Wait counter is 4 bits. WAIT_CYCLES outside 1..15 is an elaboration error.

## Timing
- Accepting edge = edge 0.
- Read Ack is high in cycle 2(WAIT_CYCLES+1)+1 after edge 0 (WAIT_CYCLES=2: cycle 7).
- Write Ack is high in cycle 2(WAIT_CYCLES+2)+1 (WAIT_CYCLES=2: cycle 9).
- Byte-mode access (see Configuration) takes a single phase: Ack in cycle (WAIT_CYCLES+1)+1 for a read, (WAIT_CYCLES+2)+1 for a write.
- Reset asserted mid-operation takes effect immediately: we/oe/cs go to 1 and the bus goes 'z with no clock. The partial access is lost, no Ack is issued, and RdData resets to 0.

## Configuration
- SRAM_CTRL_BYTE_ACCESS_EN defined:
  - Adds input port ByteMode (1 bit, sampled with Req).
  - ByteMode=1 does a single-byte access at the full Addr, including bit 0. Write uses WrData[7:0]. Read returns {8'h00, byte} in RdData.
- Undefined: the port is absent and all accesses are word accesses.

## Test plan
- Reset: hold nReset=0 for 3 cycles -> cs=we=oe=1, SramData='z, Busy=0, Ack=0, RdData=0.
- Read after reset, SRAM filled with 8'h55, Addr=21'h000000, WAIT_CYCLES=2 -> Ack in cycle 7 only, RdData=16'h5555. Assertion monitor confirms never (~we && ~oe).
- Write 16'hBEEF at 21'h000004, then read 21'h000005 -> SRAM bytes 4/5 = 8'hBE/8'hEF, read returns 16'hBEEF, write Ack in cycle 9.
- Req held high during Busy with alternating Write/Addr values -> only the request at each IDLE edge is accepted, exactly one Ack per accepted request.
- With SRAM_CTRL_BYTE_ACCESS_EN: write word 16'h1234 at address 6, then byte write 8'hA5 at address 7, then word read at address 6 -> 16'h12A5. Byte read at address 6 -> 16'h0012.
- nReset pulsed low in the second STROBE cycle of a write -> we=1 and SramData='z without waiting for a clock, no Ack. A following read of 21'h000000 completes normally.
